// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width; never zero so WIDTH=1 still has a legal counter.
    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand-in / result-out valid-ready bundle for the serial adder.
interface serial_add_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );
endinterface

// File: rtl/serial_add_sequencer_half_add.sv
// Single half adder: out = {carry, sum} of the two input bits.
module half_add (
    input  logic [1:0] arg_0,
    output logic [1:0] out
);
    assign out = {&arg_0, ^arg_0};
endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one shared full-add slice, LSB first, one bit per clock.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clock,
    input  logic        reset_n,
    serial_add_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [1:0] ha1, ha2;
    logic       sum_bit;
    logic       carry_nxt;
    logic       last_bit;

    // Operands shift right, so bit 0 of each register is always the current bit.
    half_add u_ha1 (.arg_0({b_q[0], a_q[0]}),   .out(ha1));
    half_add u_ha2 (.arg_0({carry_q, ha1[0]}),  .out(ha2));

    assign sum_bit   = ha2[0];
    assign carry_nxt = ha1[1] | ha2[1];
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = sum_bit;
                carry_d          = carry_nxt;
                cnt_d            = cnt_q + 1'b1;
                if (last_bit) begin
                    // Result is complete this cycle; freeze it in the output registers.
                    cnt_d   = '0;
                    sum_d   = res_d;
                    cout_d  = carry_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_carry = cout_q;

endmodule
